// File: rtl/an_encoder_24bits_clk.sv
// ---------------------------------------------------------------------------
// an_encoder_24bits_clk
//
// Sequential AN-code encoder. Computes the codeword W = A*N for a data word N
// with a shift-and-add multiplier that walks the A_BITS bits of the constant
// A, one bit per cycle. It can optionally inject a single signed arithmetic
// error of +/-2^(|l|-1) into the codeword. The location l uses the same
// signed convention (l = +/-1 .. +/-W_BITS) as the location-based SEC
// decoder that sits downstream.
//
// Timing: the edge that accepts start is edge 0. MULT runs for A_BITS cycles
// and INJ for one more, so valid pulses after edge A_BITS+1.
//
// Ports:
//   clk      in   1          clock, rising edge
//   rst_n    in   1          synchronous reset, ACTIVE HIGH (1 = reset)
//   start    in   1          encode request, sampled only in IDLE
//   N_in     in   N_BITS     data word, captured on the accepting edge
//   inj_en   in   1          enable error injection, captured with N_in
//   inj_loc  in   L_BITS+1   signed error location l, captured with N_in
//   busy     out  1          encode in progress
//   valid    out  1          one-cycle pulse, W holds a new result
//   W        out  W_BITS     codeword, held until the next valid
//   inj_bad  out  1          one-cycle pulse with valid, l was out of range
// ---------------------------------------------------------------------------
module an_encoder_24bits_clk #(
    parameter int A      = 67,
    parameter int A_BITS = 7,
    parameter int N_BITS = 24,
    parameter int W_BITS = 32,
    parameter int L_BITS = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_BITS-1:0] N_in,
    input  logic              inj_en,
    input  logic [L_BITS:0]   inj_loc,
    output logic              busy,
    output logic              valid,
    output logic [W_BITS-1:0] W,
    output logic              inj_bad
);

    localparam int CNT_W = (A_BITS > 1) ? $clog2(A_BITS) : 1;

    localparam logic [A_BITS-1:0] A_VEC    = A_BITS'(A);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(A_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [L_BITS:0]   LOC_MAX  = (L_BITS+1)'(W_BITS);
    localparam logic [L_BITS:0]   LOC_ZERO = {(L_BITS+1){1'b0}};
    localparam logic [L_BITS:0]   LOC_ONE  = {{L_BITS{1'b0}}, 1'b1};
    localparam logic [W_BITS-1:0] W_ZERO   = {W_BITS{1'b0}};
    localparam logic [W_BITS-1:0] W_ONE    = {{(W_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_INJ  = 2'd2
    } state_t;

    // Magnitude of a two's-complement location. The most negative value
    // (-2^L_BITS) maps to 2^L_BITS as an unsigned number, which is always
    // larger than W_BITS and therefore lands in the out-of-range path.
    function automatic logic [L_BITS:0] loc_mag(input logic [L_BITS:0] loc);
        logic [L_BITS:0] mag;
        if (loc[L_BITS]) begin
            mag = ~loc + LOC_ONE;
        end else begin
            mag = loc;
        end
        return mag;
    endfunction

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [W_BITS-1:0]   r_acc;
    logic [N_BITS-1:0]   r_n;
    logic                r_inj_en;
    logic [L_BITS:0]     r_loc;
    logic                r_busy;
    logic                r_valid;
    logic [W_BITS-1:0]   r_w;
    logic                r_inj_bad;

    logic [W_BITS-1:0]   w_addend;
    logic [L_BITS:0]     w_mag;
    logic                w_loc_ok;
    logic [W_BITS-1:0]   w_err;
    logic [W_BITS-1:0]   w_injected;

    // Partial product for the current multiplier bit and the injected codeword.
    always_comb begin
        w_addend   = W_ZERO;
        w_mag      = loc_mag(r_loc);
        w_loc_ok   = 1'b0;
        w_err      = W_ZERO;
        w_injected = r_acc;

        if (A_VEC[r_cnt]) begin
            w_addend = {{(W_BITS-N_BITS){1'b0}}, r_n} << r_cnt;
        end else begin
            w_addend = W_ZERO;
        end

        w_loc_ok = (w_mag != LOC_ZERO) && (w_mag <= LOC_MAX);

        if (w_loc_ok) begin
            w_err = W_ONE << (w_mag - LOC_ONE);
        end else begin
            w_err = W_ZERO;
        end

        // Modulo-2^W_BITS arithmetic: wrap is intended, no saturation.
        if (r_loc[L_BITS]) begin
            w_injected = r_acc - w_err;
        end else begin
            w_injected = r_acc + w_err;
        end
    end

    // Control FSM, multiplier datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= CNT_ZERO;
            r_acc     <= W_ZERO;
            r_n       <= {N_BITS{1'b0}};
            r_inj_en  <= 1'b0;
            r_loc     <= LOC_ZERO;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_w       <= W_ZERO;
            r_inj_bad <= 1'b0;
        end else begin
            // Pulses default low; only INJ raises them for a single cycle.
            r_valid   <= 1'b0;
            r_inj_bad <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_n      <= N_in;
                        r_inj_en <= inj_en;
                        r_loc    <= inj_loc;
                        r_acc    <= W_ZERO;
                        r_cnt    <= CNT_ZERO;
                        r_busy   <= 1'b1;
                        r_state  <= ST_MULT;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_MULT: begin
                    r_acc <= r_acc + w_addend;
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= CNT_ZERO;
                        r_state <= ST_INJ;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                        r_state <= ST_MULT;
                    end
                end
                ST_INJ: begin
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                    if (r_inj_en && w_loc_ok) begin
                        r_w       <= w_injected;
                        r_inj_bad <= 1'b0;
                    end else begin
                        r_w       <= r_acc;
                        r_inj_bad <= r_inj_en;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign valid   = r_valid;
    assign W       = r_w;
    assign inj_bad = r_inj_bad;

endmodule
